// File: rtl/wave_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : wave_trigger_capture
//  Description : Sample-tick generator, 12->10 bit decimation with optional x3
//                zoom, and rising mid-scale trigger that frames DEPTH samples
//                with column addresses for the waveform display memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_trigger_capture #(
    parameter int CLK_DIV = 5000,
    parameter int DEPTH   = 1280,
    parameter int HYST    = 16,
    parameter int TIMEOUT = 2560
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] mic_in,
    input  logic        mic_valid,
    input  logic        freeze,
    input  logic        zoom,
    output logic        sample_tick,
    output logic [9:0]  wave_sample,
    output logic [10:0] wave_addr,
    output logic        wave_valid,
    output logic        frame_start,
    output logic        triggered
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT - 1);
    localparam logic [10:0]        c_ADDR_LAST = 11'(DEPTH - 1);
    localparam logic [9:0]         c_TRIG_LO   = 10'(512 - HYST);
    localparam logic [9:0]         c_TRIG_HI   = 10'(512 + HYST);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div;
    logic [9:0]          r_hold;
    logic [c_TO_W-1:0]   r_timeout;
    logic [c_TO_W-1:0]   w_to_nxt;
    logic [10:0]         r_col;
    logic [10:0]         w_col_nxt;
    logic [10:0]         w_emit_addr;
    logic                w_emit;
    logic                w_trig_load;
    logic                w_trig_val;
    logic [9:0]          w_s;
    logic signed [12:0]  w_gain;
    logic [9:0]          w_z;
    logic [1:0]          w_unused_lsb;

    assign sample_tick  = (r_div == c_DIV_LAST);
    assign w_unused_lsb = mic_in[1:0];

    // A strobe coinciding with the tick feeds that tick directly.
    assign w_s    = mic_valid ? mic_in[11:2] : r_hold;
    assign w_gain = 13'sd3 * ($signed({3'b000, w_s}) - 13'sd512) + 13'sd512;

    always_comb begin
        w_z = w_s;
        if (zoom) begin
            if (w_gain < 13'sd0) begin
                w_z = 10'd0;
            end else if (w_gain > 13'sd1023) begin
                w_z = 10'd1023;
            end else begin
                w_z = w_gain[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_addr = r_col;
        w_col_nxt   = r_col;
        w_to_nxt    = r_timeout;
        w_trig_load = 1'b0;
        w_trig_val  = 1'b0;
        if (sample_tick) begin
            case (r_state)
                ST_ARM, ST_LOW: begin
                    // Saturate so a freeze at the last count cannot wrap it.
                    if (r_timeout != c_TO_LAST) begin
                        w_to_nxt = r_timeout + 1'b1;
                    end
                    if (freeze) begin
                        w_state_nxt = ST_HOLD;
                    end else if (r_timeout == c_TO_LAST) begin
                        w_trig_load = 1'b1;
                        w_trig_val  = 1'b0;
                    end else if (r_state == ST_LOW && w_z >= c_TRIG_HI) begin
                        w_trig_load = 1'b1;
                        w_trig_val  = 1'b1;
                    end else if (r_state == ST_ARM && w_z < c_TRIG_LO) begin
                        w_state_nxt = ST_LOW;
                    end
                    // The sample that starts a frame is itself column 0.
                    if (w_trig_load) begin
                        w_state_nxt = ST_RUN;
                        w_emit      = 1'b1;
                        w_emit_addr = 11'd0;
                        w_col_nxt   = 11'd1;
                        w_to_nxt    = '0;
                    end
                end
                ST_RUN: begin
                    w_emit = 1'b1;
                    if (r_col == c_ADDR_LAST) begin
                        w_col_nxt   = 11'd0;
                        w_state_nxt = freeze ? ST_HOLD : ST_ARM;
                    end else begin
                        w_col_nxt = r_col + 11'd1;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        w_state_nxt = ST_ARM;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_hold      <= '0;
            r_timeout   <= '0;
            r_col       <= '0;
            wave_valid  <= 1'b0;
            frame_start <= 1'b0;
            wave_sample <= '0;
            wave_addr   <= '0;
            triggered   <= 1'b0;
        end else begin
            r_div <= sample_tick ? '0 : r_div + 1'b1;
            if (mic_valid) begin
                r_hold <= mic_in[11:2];
            end
            r_timeout   <= w_to_nxt;
            r_col       <= w_col_nxt;
            wave_valid  <= w_emit;
            frame_start <= w_emit && (w_emit_addr == 11'd0);
            if (w_emit) begin
                wave_sample <= w_z;
                wave_addr   <= w_emit_addr;
            end
            if (w_trig_load) begin
                triggered <= w_trig_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_trigger_capture
//  Description : Directed self-checking bench for wave_trigger_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_trigger_capture;

    localparam int CLK_DIV = 5;
    localparam int DEPTH   = 1280;
    localparam int HYST    = 16;
    localparam int TIMEOUT = 2560;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mic_in = 12'd0;
    logic        mic_valid = 1'b0;
    logic        freeze = 1'b0;
    logic        zoom = 1'b0;
    logic        sample_tick;
    logic [9:0]  wave_sample;
    logic [10:0] wave_addr;
    logic        wave_valid;
    logic        frame_start;
    logic        triggered;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wave_trigger_capture #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .HYST    (HYST),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .mic_in      (mic_in),
        .mic_valid   (mic_valid),
        .freeze      (freeze),
        .zoom        (zoom),
        .sample_tick (sample_tick),
        .wave_sample (wave_sample),
        .wave_addr   (wave_addr),
        .wave_valid  (wave_valid),
        .frame_start (frame_start),
        .triggered   (triggered)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (sample_tick !== 1'b1 && n < 2 * CLK_DIV) begin
            step();
            n++;
        end
        if (sample_tick !== 1'b1) begin
            check_eq("tick_wait", 32'(sample_tick), 32'd1);
        end
    endtask

    // mic_valid is pulsed only in the tick cycle itself.
    task automatic do_tick(input logic [11:0] m);
        mic_in    = m;
        mic_valid = 1'b0;
        wait_tick();
        mic_valid = 1'b1;
        step();
        mic_valid = 1'b0;
    endtask

    // Load the hold register early, then present junk without a strobe.
    task automatic do_tick_held(input logic [11:0] m_load, input logic [11:0] m_junk);
        mic_in    = m_load;
        mic_valid = 1'b1;
        step();
        mic_valid = 1'b0;
        mic_in    = m_junk;
        wait_tick();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_strobe(input string tag, input int addr, input int smp);
        check_eq({tag, "_valid"}, 32'(wave_valid), 32'd1);
        check_eq({tag, "_addr"}, 32'(wave_addr), 32'(addr));
        check_eq({tag, "_sample"}, 32'(wave_sample), 32'(smp));
        check_eq({tag, "_fs"}, 32'(frame_start), 32'(addr == 0));
    endtask

    task automatic expect_zero(input string tag);
        check_eq({tag, "_tick"}, 32'(sample_tick), 32'd0);
        check_eq({tag, "_valid"}, 32'(wave_valid), 32'd0);
        check_eq({tag, "_sample"}, 32'(wave_sample), 32'd0);
        check_eq({tag, "_addr"}, 32'(wave_addr), 32'd0);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
        check_eq({tag, "_trig"}, 32'(triggered), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int strobes;

        // Reset state and divider cadence
        repeat (3) step();
        expect_zero("rst");
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check_eq($sformatf("div_k%0d", k), 32'(sample_tick), 32'((k % 5) == 4));
        end

        // Ramp in steps of 16 codes: trigger at mic=2112 (s=528)
        do_reset();
        strobes = 0;
        for (int k = 0; k < 132; k++) begin
            do_tick(12'(16 * k));
            strobes += int'(wave_valid);
        end
        check_eq("ramp_pre_quiet", 32'(strobes), 32'd0);
        for (int n = 0; n < DEPTH; n++) begin
            m = 16 * (132 + n);
            if (m > 4095) m = 4095;
            do_tick(12'(m));
            expect_strobe("ramp", n, m >> 2);
            if (n == 0) begin
                check_eq("ramp_trig", 32'(triggered), 32'd1);
            end
        end
        do_tick(12'hFFF);
        check_eq("ramp_post_valid", 32'(wave_valid), 32'd0);
        check_eq("ramp_addr_hold", 32'(wave_addr), 32'(DEPTH - 1));

        // Constant mid-scale: timeout frame after TIMEOUT ticks
        do_reset();
        strobes = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            do_tick(12'h800);
            strobes += int'(wave_valid);
        end
        check_eq("to_quiet", 32'(strobes), 32'd0);
        do_tick(12'h800);
        expect_strobe("to_first", 0, 512);
        check_eq("to_trig", 32'(triggered), 32'd0);

        // Zoom inside the timeout frame
        zoom = 1'b1;
        do_tick(12'hC00);
        expect_strobe("zoom_c00", 1, 1023);
        do_tick(12'h800);
        expect_strobe("zoom_800", 2, 512);
        do_tick(12'h880);
        expect_strobe("zoom_880", 3, 608);
        do_tick(12'h400);
        expect_strobe("zoom_400", 4, 0);
        zoom = 1'b0;
        do_tick(12'h880);
        expect_strobe("nozoom_880", 5, 544);
        zoom = 1'b1;
        do_tick_held(12'h880, 12'hFFF);
        expect_strobe("held_880", 6, 608);
        zoom = 1'b0;
        for (int n = 7; n < DEPTH; n++) begin
            do_tick(12'h800);
            check_eq("to_valid", 32'(wave_valid), 32'd1);
            check_eq("to_addr", 32'(wave_addr), 32'(n));
        end
        do_tick(12'h800);
        check_eq("to_post_valid", 32'(wave_valid), 32'd0);

        // Freeze raised after column 600
        do_reset();
        do_tick(12'h000);
        do_tick(12'h840);
        expect_strobe("frz_first", 0, 528);
        check_eq("frz_trig", 32'(triggered), 32'd1);
        for (int n = 1; n <= 600; n++) begin
            do_tick(12'h800);
            check_eq("frz_pre_addr", 32'(wave_addr), 32'(n));
        end
        freeze = 1'b1;
        for (int n = 601; n < DEPTH; n++) begin
            do_tick(12'h800);
            check_eq("frz_valid", 32'(wave_valid), 32'd1);
            check_eq("frz_addr", 32'(wave_addr), 32'(n));
        end
        strobes = 0;
        for (int k = 0; k < 4; k++) begin
            do_tick(k[0] ? 12'h840 : 12'h000);
            strobes += int'(wave_valid);
        end
        check_eq("hold_quiet", 32'(strobes), 32'd0);
        check_eq("hold_trig", 32'(triggered), 32'd1);
        freeze = 1'b0;
        do_tick(12'h840);
        check_eq("unfrz_arm_valid", 32'(wave_valid), 32'd0);
        do_tick(12'h000);
        check_eq("unfrz_low_valid", 32'(wave_valid), 32'd0);
        do_tick(12'h840);
        expect_strobe("unfrz_first", 0, 528);
        check_eq("unfrz_trig", 32'(triggered), 32'd1);

        // Reset pulsed after column 300
        for (int n = 1; n <= 300; n++) begin
            do_tick(12'h800);
            check_eq("rst_mid_addr", 32'(wave_addr), 32'(n));
        end
        reset = 1'b1;
        step();
        expect_zero("rst_mid");
        reset = 1'b0;
        do_tick(12'h840);
        check_eq("rst_arm_valid", 32'(wave_valid), 32'd0);
        do_tick(12'h000);
        check_eq("rst_low_valid", 32'(wave_valid), 32'd0);
        do_tick(12'h840);
        expect_strobe("rst_restart", 0, 528);
        check_eq("rst_restart_trig", 32'(triggered), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
